instruction_fetch_unit: RTL

- Fetch stage directly downstream of the program counter. Takes the current PC address, requests the instruction word from instruction memory over a request/ready handshake, and buffers returned {pc, instruction} pairs in a small FIFO for decode.
- Drives the PC's halt input so the PC advances only when a fetch has been committed.
- Supports flush (branch/jump redirect) with cancellation of an in-flight fetch.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: bus widths, fetch FSM states and the buffered {pc, instr} entry.
package cpu_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer; the head is read combinationally from the registered array.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     store [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             pop_eff;
   logic             push_eff;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = store[rd_ptr];

   // A pop on a full buffer frees the slot the simultaneous push lands in.
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) begin
            store[wr_ptr] <= din;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_eff, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request at a time, results buffered for decode,
// PC held until a fetch commits.
module instruction_fetch_unit
   import cpu_pkg::fetch_state_t, cpu_pkg::IDLE, cpu_pkg::WAIT, cpu_pkg::DRAIN;
#(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      endereco_atual,
   input  logic                   flush,
   output logic                   mem_req,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic                   mem_ready,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   instr_valid,
   output logic [DATA_W-1:0]      instr_out,
   output logic [ADDR_W-1:0]      instr_pc,
   input  logic                   instr_accept,
   output logic                   pc_halt,
   output fetch_state_t           dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
);

   fetch_state_t             state;
   logic                     commit;
   logic                     slot_free;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [ADDR_W+DATA_W-1:0] fifo_dout;

   // Handshakes: the memory transfer completes on a cycle with mem_req=1 and mem_ready=1, and
   // mem_addr is held until then; decode transfers the head on instr_valid=1 and instr_accept=1.
   assign commit    = (state == WAIT) && mem_ready && !flush;
   assign slot_free = !fifo_full || (instr_accept && instr_valid);
   assign pc_halt   = !commit;
   assign dbg_state = state;

   assign instr_valid = !fifo_empty;
   assign instr_pc    = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
   assign instr_out   = fifo_dout[DATA_W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush && slot_free) begin
                  mem_addr <= endereco_atual;
                  mem_req  <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (flush) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // The memory cannot be aborted, so wait out the cancelled response and drop it.
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + DATA_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (commit),
      .pop   (instr_accept),
      .din   ({mem_addr, mem_rdata}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (dbg_count)
   );

endmodule
